// File: rtl/cpu_wb_cla_mult_ctrl.sv
// cpu_wb_cla_mult_ctrl: sequential shift-and-add unsigned multiplier.
// One DATA_WID-wide carry-lookahead adder is reused once per clock, for DATA_WID
// iterations, to build an exact 2*DATA_WID-bit product. Operands come in and the
// result goes out through valid/ready handshakes. The unit sits beside the ALU.

// cpu_wb_cla_adder: generate/propagate adder used as the multiplier's accumulator.
module cpu_wb_cla_adder #(
    parameter int WID = 32
) (
    input  logic [WID-1:0] i_in1,
    input  logic [WID-1:0] i_in2,
    input  logic           i_carry_in,
    output logic [WID-1:0] o_sum,
    output logic           o_carry_out
);

    logic [WID-1:0] w_gen;
    logic [WID-1:0] w_prop;
    logic           w_carry;

    assign w_gen  = i_in1 & i_in2;
    assign w_prop = i_in1 ^ i_in2;

    // Carry chain from the per-bit generate/propagate terms; the final carry is the adder carry out
    always_comb begin
        w_carry = i_carry_in;
        o_sum   = '0;
        for (int i = 0; i < WID; i++) begin
            o_sum[i] = w_prop[i] ^ w_carry;
            w_carry  = w_gen[i] | (w_prop[i] & w_carry);
        end
        o_carry_out = w_carry;
    end

endmodule

module cpu_wb_cla_mult_ctrl #(
    parameter int DATA_WID = 32,
    parameter int CNT_WID  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [DATA_WID-1:0]   op_a,
    input  logic [DATA_WID-1:0]   op_b,
    input  logic                  abort,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [2*DATA_WID-1:0] product,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic                  r_armed;
    logic [DATA_WID-1:0]   r_mcand;
    logic [DATA_WID-1:0]   r_accHi;
    logic [DATA_WID-1:0]   r_accLo;
    logic [CNT_WID-1:0]    r_cnt;
    logic [DATA_WID-1:0]   w_addIn2;
    logic [DATA_WID-1:0]   w_sum;
    logic                  w_cout;
    logic                  w_accept;
    logic                  w_lastIter;

    // The partial-product addend is the multiplicand when the multiplier LSB is set
    assign w_addIn2   = r_accLo[0] ? r_mcand : '0;
    assign w_lastIter = (r_cnt == CNT_WID'(DATA_WID - 1));
    assign product    = {r_accHi, r_accLo};

    cpu_wb_cla_adder #(
        .WID(DATA_WID)
    ) u_adder (
        .i_in1      (r_accHi),
        .i_in2      (w_addIn2),
        .i_carry_in (1'b0),
        .o_sum      (w_sum),
        .o_carry_out(w_cout)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Holds start_ready low until the first clock edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    // Next-state and handshake outputs; abort always returns to IDLE and beats start_valid
    always_comb begin
        w_nextState = r_state;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                start_ready = r_armed;
                if (!abort && start_valid && r_armed) begin
                    w_accept    = 1'b1;
                    w_nextState = ST_CALC;
                end
            end
            ST_CALC: begin
                busy = 1'b1;
                if (abort) begin
                    w_nextState = ST_IDLE;
                end else if (w_lastIter) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (abort || res_ready) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Datapath: load operands on accept, then add-and-shift right once per CALC cycle.
    // Registers are left alone on abort and after the result handshake so product keeps the last result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand <= '0;
            r_accHi <= '0;
            r_accLo <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_mcand <= op_a;
            r_accHi <= '0;
            r_accLo <= op_b;
            r_cnt   <= '0;
        end else if (r_state == ST_CALC && !abort) begin
            {r_accHi, r_accLo} <= {w_cout, w_sum, r_accLo[DATA_WID-1:1]};
            r_cnt              <= r_cnt + CNT_WID'(1);
        end
    end

endmodule

// File: tb/tb_cpu_wb_cla_mult_ctrl.sv
// tb_cpu_wb_cla_mult_ctrl: directed checks of the shift-and-add multiplier controller.
module tb_cpu_wb_cla_mult_ctrl;

    localparam int DW = 32;

    logic            clk;
    logic            rst_n;
    logic            start_valid;
    logic            start_ready;
    logic [DW-1:0]   op_a;
    logic [DW-1:0]   op_b;
    logic            abort;
    logic            res_valid;
    logic            res_ready;
    logic [2*DW-1:0] product;
    logic            busy;

    int checks;
    int failures;

    cpu_wb_cla_mult_ctrl #(
        .DATA_WID(DW),
        .CNT_WID (6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .abort      (abort),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .product    (product),
        .busy       (busy)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Waits for start_ready, presents operands for one edge; returns with the accept edge just past
    task automatic applyStimulus(input logic [DW-1:0] a, input logic [DW-1:0] b);
        @(negedge clk);
        for (int i = 0; i < 50 && !start_ready; i++) @(negedge clk);
        op_a        = a;
        op_b        = b;
        start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
    endtask

    // Counts edges after acceptance until res_valid is seen; -1 on timeout
    task automatic waitResult(output int cycles);
        cycles = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (res_valid) begin
                cycles = n;
                break;
            end
        end
    endtask

    // Takes the result with a one-cycle res_ready pulse
    task automatic takeResult();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        start_valid = 1'b0;
        op_a        = '0;
        op_b        = '0;
        abort       = 1'b0;
        res_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({start_ready, res_valid, busy} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_flags got=%b expected=000", {start_ready, res_valid, busy});
        end
        checks++;
        if (product !== 64'd0) begin
            failures++;
            $display("[TB] FAIL reset_product got=%h expected=0", product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        checks++;
        if (start_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ready_before_edge got=%b expected=0", start_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (start_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ready_after_edge got=%b expected=1", start_ready);
        end
    endtask

    task automatic test_basic();
        int cyc;
        applyStimulus(32'd3, 32'd5);
        checks++;
        if ({start_ready, busy} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL basic_calc_flags got=%b expected=01", {start_ready, busy});
        end
        waitResult(cyc);
        checks++;
        if (cyc !== 32) begin
            failures++;
            $display("[TB] FAIL basic_latency got=%0d expected=32", cyc);
        end
        checks++;
        if (product !== 64'h000000000000000F) begin
            failures++;
            $display("[TB] FAIL basic_product got=%h expected=000000000000000f", product);
        end
        takeResult();
        checks++;
        if ({res_valid, busy, start_ready} !== 3'b001) begin
            failures++;
            $display("[TB] FAIL basic_after_take got=%b expected=001", {res_valid, busy, start_ready});
        end
        checks++;
        if (product !== 64'h000000000000000F) begin
            failures++;
            $display("[TB] FAIL basic_retain got=%h expected=000000000000000f", product);
        end
    endtask

    task automatic test_carry();
        int cyc;
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF);
        waitResult(cyc);
        checks++;
        if (cyc !== 32 || product !== 64'hFFFFFFFE00000001) begin
            failures++;
            $display("[TB] FAIL carry_product got=%h cyc=%0d expected=fffffffe00000001 cyc=32", product, cyc);
        end
        takeResult();
    endtask

    task automatic test_zero();
        int cyc;
        applyStimulus(32'd0, 32'h12345678);
        waitResult(cyc);
        checks++;
        if (cyc !== 32 || product !== 64'd0) begin
            failures++;
            $display("[TB] FAIL zero_product got=%h cyc=%0d expected=0 cyc=32", product, cyc);
        end
        takeResult();
    endtask

    task automatic test_back_to_back();
        int cyc;
        int badHold;
        applyStimulus(32'd6, 32'd7);
        waitResult(cyc);
        checks++;
        if (cyc !== 32 || product !== 64'd42) begin
            failures++;
            $display("[TB] FAIL bp_first got=%h cyc=%0d expected=2a cyc=32", product, cyc);
        end
        op_a        = 32'd10;
        op_b        = 32'd11;
        start_valid = 1'b1;
        badHold     = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (res_valid !== 1'b1 || product !== 64'd42 || start_ready !== 1'b0) badHold++;
        end
        checks++;
        if (badHold !== 0) begin
            failures++;
            $display("[TB] FAIL bp_hold bad_cycles=%0d expected=0", badHold);
        end
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        checks++;
        if ({res_valid, busy, start_ready} !== 3'b001) begin
            failures++;
            $display("[TB] FAIL bp_idle got=%b expected=001", {res_valid, busy, start_ready});
        end
        @(posedge clk);
        #1 start_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_accept got=%b expected=1", busy);
        end
        waitResult(cyc);
        checks++;
        if (cyc !== 32 || product !== 64'd110) begin
            failures++;
            $display("[TB] FAIL bp_second got=%h cyc=%0d expected=6e cyc=32", product, cyc);
        end
        takeResult();
    endtask

    task automatic test_abort();
        int cyc;
        int sawValid;
        applyStimulus(32'd100, 32'd200);
        repeat (9) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        checks++;
        if ({busy, res_valid, start_ready} !== 3'b001) begin
            failures++;
            $display("[TB] FAIL abort_calc got=%b expected=001", {busy, res_valid, start_ready});
        end
        sawValid = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (res_valid) sawValid++;
        end
        checks++;
        if (sawValid !== 0) begin
            failures++;
            $display("[TB] FAIL abort_no_result got=%0d expected=0", sawValid);
        end
        // abort and start_valid together in IDLE: nothing accepted
        @(negedge clk);
        op_a        = 32'd1;
        op_b        = 32'd1;
        start_valid = 1'b1;
        abort       = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        abort       = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_idle got=%b expected=0", busy);
        end
        applyStimulus(32'd7, 32'd9);
        waitResult(cyc);
        checks++;
        if (cyc !== 32 || product !== 64'd63) begin
            failures++;
            $display("[TB] FAIL abort_then_mul got=%h cyc=%0d expected=3f cyc=32", product, cyc);
        end
        // abort in DONE together with res_ready: result dropped, registers kept
        @(negedge clk);
        abort     = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        abort     = 1'b0;
        res_ready = 1'b0;
        checks++;
        if ({res_valid, busy} !== 2'b00 || product !== 64'd63) begin
            failures++;
            $display("[TB] FAIL abort_done got=%b/%h expected=00/3f", {res_valid, busy}, product);
        end
    endtask

    task automatic test_async_reset();
        int cyc;
        applyStimulus(32'd5, 32'd5);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({start_ready, res_valid, busy} !== 3'b000 || product !== 64'd0) begin
            failures++;
            $display("[TB] FAIL async_reset got=%b/%h expected=000/0", {start_ready, res_valid, busy}, product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(32'h80000000, 32'd2);
        waitResult(cyc);
        checks++;
        if (cyc !== 32 || product !== 64'h0000000100000000) begin
            failures++;
            $display("[TB] FAIL async_after got=%h cyc=%0d expected=0000000100000000 cyc=32", product, cyc);
        end
        takeResult();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_carry();
        test_zero();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_wb_cla_mult_ctrl.md
Name: cpu_wb_cla_mult_ctrl

Overview:
- Sequential shift-and-add unsigned multiplier controller.
- Time-shares one internal cpu_wb_cla_adder instance, DATA_WID wide, across DATA_WID iterations to form a 2*DATA_WID product.
- Operands are accepted and results returned through valid/ready handshakes.
- Sits beside the integer ALU as the multi-cycle multiply unit.

Parameters:
DATA_WID, 32, operand width; product is 2*DATA_WID. Legal values are 2..64.
CNT_WID, 6, iteration counter width; must satisfy 2**CNT_WID > DATA_WID.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start_valid  input  1  operands op_a/op_b valid
start_ready  output  1  controller can accept operands
op_a  input  DATA_WID  multiplicand
op_b  input  DATA_WID  multiplier
abort  input  1  synchronous cancel of the operation in flight
res_valid  output  1  product valid
res_ready  input  1  consumer accepts product
product  output  2*DATA_WID  result
busy  output  1  high in CALC or DONE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; all outputs forced low/zero: start_ready=0, res_valid=0, busy=0, product=0.
  - Internal registers mcand, acc_hi, acc_lo and cnt all cleared.
  - start_ready may rise only after the first clock edge with rst_n high.
- States: IDLE, CALC, DONE. Encoding is free.
- IDLE:
  - start_ready=1.
  - On start_valid&&start_ready: mcand<=op_a, acc_hi<=0, acc_lo<=op_b, cnt<=0, go to CALC.
- CALC, one iteration per clock:
  - Adder inputs: in1=acc_hi; in2 = acc_lo[0] ? mcand : 0; carry_in=0.
  - Update {acc_hi,acc_lo} <= {carry_out, sum, acc_lo[DATA_WID-1:1]}, a logical right shift with the adder carry entering the MSB.
  - cnt increments. When cnt==DATA_WID-1 the iteration completes and the state moves to DONE.
  - start_ready=0; start_valid is ignored.
- DONE:
  - res_valid=1.
  - product presents {acc_hi,acc_lo} combinationally, or from an equivalent register, and is stable while res_valid=1.
  - On res_valid&&res_ready, go to IDLE.
  - res_valid must not drop without res_ready, except on abort or reset.
- Latency:
  - Operands are accepted at edge E.
  - res_valid is high after edge E+DATA_WID, i.e. DATA_WID cycles in CALC.
  - The fastest back-to-back rate is one result per DATA_WID+2 cycles: IDLE, CALC×DATA_WID, DONE.
- product after handshake: retains the last result after the res handshake, until the next accept overwrites the internal registers. In IDLE it shows the last result; it is 0 after reset.
- abort:
  - Effective in any state at the next edge: state<=IDLE, res_valid<=0.
  - Internal registers are not cleared.
  - abort in IDLE coinciding with start_valid: abort wins and the operands are not accepted.
  - abort in DONE coinciding with res_ready: the result is dropped and the state returns to IDLE; the bench must treat this as no transfer.
- Reset mid-CALC or mid-DONE: the operation is lost and no res_valid pulse follows.
- Width rules:
  - The product is exact (no truncation): max (2^DATA_WID-1)^2 fits in 2*DATA_WID bits.
  - The adder carry_out is never lost because it shifts into acc_hi MSB.
- busy = (state!=IDLE).

Test Plan:
- Basic multiply: reset, op_a=3, op_b=5, start_valid 1 cycle -> res_valid rises exactly 32 cycles after acceptance edge; product=0x000000000000000F.
- Carry path: op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> product=0xFFFFFFFE00000001.
- Zero operands: op_a=0, op_b=0x12345678 -> product=0.
- Backpressure: res_ready held 0 for 10 cycles after res_valid, with start_valid=1 throughout -> res_valid and product stable, start_ready=0, no new acceptance. On res_ready=1, next cycle is IDLE and the new operands are accepted.
- Abort: assert abort in the 10th CALC cycle -> IDLE next edge, no res_valid. Then 7*9 -> product=63 with full latency.
- Async reset: drop rst_n mid-CALC, between clock edges -> outputs zero immediately. After release, 0x80000000*2 -> product=0x0000000100000000.
